id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register plus operand front-end for the EX-stage ALU of the 5-stage CPU.
//   Latches decoded ID fields and turns ALUOp+funct into the 3-bit ALU ctl code.
//   Forwards EX/MEM and MEM/WB results into operands a/b and detects load-use hazards.
//   Outputs feed the ALU (a, b, ctl, shamt) and the EX/MEM register directly.
// PARAMETERS
//   DATA_W   32  datapath width
//   REG_AW   5   register-index width
// PORTS
//   clk              in   1       rising-edge clock
//   rst              in   1       asynchronous reset, active-high
//   stall            in   1       hold all registered state (downstream back-pressure)
//   flush            in   1       load a bubble (branch taken / exception)
//   id_valid         in   1       ID holds a real instruction
//   id_rs_data       in   DATA_W  register-file read port A
//   id_rt_data       in   DATA_W  register-file read port B
//   id_imm           in   DATA_W  sign-extended immediate
//   id_rs,id_rt,id_rd in  REG_AW  register indices
//   id_shamt         in   5       shift amount
//   id_funct         in   6       R-type funct field
//   id_alu_op        in   2       00 add, 01 sub, 10 R-type, 11 reserved
//   id_alu_src       in   1       1: b = immediate
//   id_reg_dst       in   1       1: dest = rd, 0: dest = rt
//   id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_beq, id_bne  in  1  controls
//   exmem_reg_write  in   1 ; exmem_rd in REG_AW ; exmem_result in DATA_W
//   memwb_reg_write  in   1 ; memwb_rd in REG_AW ; memwb_data   in DATA_W
//   ex_a, ex_b       out  DATA_W  ALU operands (forwarded, muxed)
//   ex_ctl           out  3       ALU control code
//   ex_shamt         out  5       shift amount to ALU
//   ex_store_data    out  DATA_W  forwarded rt value for stores
//   ex_wr_reg        out  REG_AW  destination register
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_beq, ex_bne  out  1
//   hazard_stall     out  1       to PC / IF-ID: hold for one cycle
//   illegal_funct    out  1       registered: R-type funct not decoded
// BEHAVIOUR
//   - rst (async): every registered field = 0; ex_valid = 0; hazard_stall reads 0.
//   - Posedge priority: flush > stall > hazard bubble > load.
//       flush: valid and all control bits := 0.
//       stall: hold everything.
//       bubble (hazard_stall=1): control bits := 0.
//       load: capture all id_* fields.
//   - 1-cycle latency: ID values appear at EX outputs one clock after capture.
//   - ctl decode (registered):
//       alu_op 00 -> 010; 01 -> 110; 11 -> 010.
//       alu_op 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000,
//         100101 -> 001, 101010 -> 111, 000000 -> 011.
//       Any other funct -> 010, illegal_funct = 1, reg_write forced 0.
//   - ex_wr_reg = id_reg_dst ? id_rd : id_rt, computed at capture.
//   - Forwarding (combinational on registered rs/rt), per operand:
//       1st: exmem_reg_write && exmem_rd != 0 && exmem_rd == reg -> exmem_result
//       2nd: memwb_reg_write && memwb_rd != 0 && memwb_rd == reg -> memwb_data
//       else: registered read data.
//       Both sources match: EX/MEM wins. Register 0 is never forwarded.
//   - Operands: ex_a = fwd(rs); ex_store_data = fwd(rt); ex_b = alu_src ? imm : fwd(rt).
//   - hazard_stall = ex_valid & ex_mem_read & id_valid & ex_wr_reg != 0
//       & (ex_wr_reg == id_rs | ex_wr_reg == id_rt).
//     Purely combinational; lasts exactly one cycle because a bubble is then loaded.
//     Suppressed (0) while stall or flush is high.
//   - flush and hazard in the same cycle: flush wins, no second bubble.
// CONFIGURATION
//   ID_EX_FORWARD_EN defined:
//     forwarding muxes as above; hazard_stall covers load-use only.
//   ID_EX_FORWARD_EN undefined:
//     ex_a / ex_b / ex_store_data use registered read data only.
//     hazard_stall also asserts on any RAW against the EX entry (reg_write)
//       or EX/MEM (exmem_reg_write, exmem_rd); dest != 0 in both cases.
//     Register file must write-first so MEM/WB needs no stall.
// TESTING
//   add r3,r1,r2 (alu_op 10, funct 100000), r1=5, r2=7 -> next cycle ctl=010, a=5, b=7, wr_reg=3.
//   EX/MEM rd=1 result=0x10 and MEM/WB rd=1 data=0x20, rs=1 -> a=0x10; rd=0 on both -> a = reg data.
//   lw r4 in EX, ID add uses r4 -> hazard_stall=1 one cycle, then ex_valid=1 with reg_write=0 bubble.
//   flush during load with id_reg_write=1 -> next cycle ex_valid=0, reg_write=0, mem_write=0.
//   stall held 3 cycles while id_* changes -> outputs unchanged; funct 100111 -> illegal_funct=1, ctl=010.
//   rst asserted mid-stream, asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, operand forwarding and load-use detection.
// Define ID_EX_FORWARD_EN for EX/MEM and MEM/WB forwarding; otherwise every RAW hazard stalls.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_beq,
  input  logic              id_bne,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_ctl,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_wr_reg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_beq,
  output logic              ex_bne,
  output logic              hazard_stall,
  output logic              illegal_funct
);

  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [REG_AW-1:0] rs_q, rt_q;
  logic              alu_src_q;
  logic [2:0]        ctl_d;
  logic              illegal_d;
  logic              ex_hit, hazard_raw;

  always_comb begin
    ctl_d     = 3'b010;
    illegal_d = 1'b0;
    if (id_alu_op == 2'b01) ctl_d = 3'b110;
    else if (id_alu_op == 2'b10) begin
      case (id_funct)
        6'b100000: ctl_d = 3'b010;
        6'b100010: ctl_d = 3'b110;
        6'b100100: ctl_d = 3'b000;
        6'b100101: ctl_d = 3'b001;
        6'b101010: ctl_d = 3'b111;
        6'b000000: ctl_d = 3'b011;
        default:   illegal_d = 1'b1;
      endcase
    end
  end

  assign ex_hit = (ex_wr_reg != '0) && (ex_wr_reg == id_rs || ex_wr_reg == id_rt);

`ifdef ID_EX_FORWARD_EN
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] r,
                                            input logic [DATA_W-1:0] d);
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd != '0 && memwb_rd == r) return memwb_data;
    return d;
  endfunction

  assign ex_a          = fwd(rs_q, rs_data_q);
  assign ex_store_data = fwd(rt_q, rt_data_q);
  assign hazard_raw    = ex_valid & ex_mem_read & id_valid & ex_hit;
`else
  logic mem_hit;
  assign mem_hit = exmem_reg_write && (exmem_rd != '0) &&
                   (exmem_rd == id_rs || exmem_rd == id_rt);
  assign ex_a          = rs_data_q;
  assign ex_store_data = rt_data_q;
  // MEM/WB is covered by the write-first register file, so only EX and EX/MEM stall.
  assign hazard_raw    = id_valid & ((ex_valid & (ex_mem_read | ex_reg_write) & ex_hit) | mem_hit);
`endif

  assign ex_b         = alu_src_q ? imm_q : ex_store_data;
  assign hazard_stall = hazard_raw & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_q <= '0; rt_data_q <= '0; imm_q <= '0;
      rs_q <= '0; rt_q <= '0; alu_src_q <= 1'b0;
      ex_ctl <= '0; ex_shamt <= '0; ex_wr_reg <= '0; ex_valid <= 1'b0;
      ex_reg_write <= 1'b0; ex_mem_read <= 1'b0; ex_mem_write <= 1'b0;
      ex_mem_to_reg <= 1'b0; ex_beq <= 1'b0; ex_bne <= 1'b0; illegal_funct <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_reg_write <= 1'b0; ex_mem_read <= 1'b0; ex_mem_write <= 1'b0;
      ex_mem_to_reg <= 1'b0; ex_beq <= 1'b0; ex_bne <= 1'b0; illegal_funct <= 1'b0;
    end else if (stall) begin
      // hold
    end else if (hazard_stall) begin
      // Bubble: the held entry becomes a no-op so the next cycle sees no hazard.
      ex_reg_write <= 1'b0; ex_mem_read <= 1'b0; ex_mem_write <= 1'b0;
      ex_mem_to_reg <= 1'b0; ex_beq <= 1'b0; ex_bne <= 1'b0; illegal_funct <= 1'b0;
    end else begin
      rs_data_q <= id_rs_data; rt_data_q <= id_rt_data; imm_q <= id_imm;
      rs_q <= id_rs; rt_q <= id_rt; alu_src_q <= id_alu_src;
      ex_ctl <= ctl_d; ex_shamt <= id_shamt;
      ex_wr_reg <= id_reg_dst ? id_rd : id_rt;
      ex_valid <= id_valid;
      ex_reg_write <= id_reg_write & ~illegal_d;
      ex_mem_read <= id_mem_read; ex_mem_write <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg; ex_beq <= id_beq; ex_bne <= id_bne;
      illegal_funct <= illegal_d;
    end
  end

endmodule
